// File: rtl/syscall_issue_ctrl_pkg.sv
// Shared definitions for the syscall issue stage: function codes, FSM state
// encodings and the default drain depth.
package syscall_issue_ctrl_pkg;

  localparam int unsigned DATA_W               = 32;
  localparam int unsigned CNT_W                = 4;
  localparam int unsigned DRAIN_CYCLES_DEFAULT = 3;

  // Syscall function codes carried in $v0
  localparam logic [DATA_W-1:0] SYSCALL_PRINT_INT = 32'd1;
  localparam logic [DATA_W-1:0] SYSCALL_EXIT      = 32'd10;
  localparam logic [DATA_W-1:0] SYSCALL_PUT_C     = 32'd11;

  typedef enum logic [1:0] {
    SYSCALL_ST_IDLE    = 2'd0,
    SYSCALL_ST_DRAIN   = 2'd1,
    SYSCALL_ST_ISSUE   = 2'd2,
    SYSCALL_ST_RELEASE = 2'd3
  } syscall_state_e;

endpackage

// File: rtl/syscall_issue_ctrl.sv
// Syscall issue sequencer: holds a decoded SYSCALL until older instructions
// have drained, then samples $v0/$a0 and fires one is_syscall pulse.
// Optional SYSCALL_COUNT_EN adds a 32-bit count of issued syscalls.
module syscall_issue_ctrl
  import syscall_issue_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_syscall_valid,
  input  logic              id_flush,
  input  logic [DATA_W-1:0] rf_v0,
  input  logic [DATA_W-1:0] rf_a0,
  output logic              stall,
  output logic              is_syscall,
  output logic [DATA_W-1:0] syscall_funct,
  output logic [DATA_W-1:0] syscall_param1
`ifdef SYSCALL_COUNT_EN
  ,
  output logic [DATA_W-1:0] syscall_count
`endif
);

  syscall_state_e   state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             issue_d;
  logic             latch_en;

  // State and drain counter register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SYSCALL_ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state, drain countdown and stall decode; stall is masked during reset
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    stall    = 1'b0;
    issue_d  = 1'b0;
    latch_en = 1'b0;
    case (state_q)
      SYSCALL_ST_IDLE: begin
        if (id_syscall_valid && !id_flush) begin
          stall   = 1'b1;
          state_d = SYSCALL_ST_DRAIN;
          count_d = CNT_W'(DRAIN_CYCLES - 1);
        end
      end
      SYSCALL_ST_DRAIN: begin
        stall = 1'b1;
        if (id_flush) begin
          state_d = SYSCALL_ST_IDLE;
        end else if (count_q != '0) begin
          count_d = count_q - CNT_W'(1);
        end else begin
          latch_en = 1'b1;
          issue_d  = 1'b1;
          state_d  = SYSCALL_ST_ISSUE;
        end
      end
      SYSCALL_ST_ISSUE: begin
        stall   = 1'b1;
        state_d = SYSCALL_ST_RELEASE;
      end
      SYSCALL_ST_RELEASE: begin
        state_d = SYSCALL_ST_IDLE;
      end
      default: begin
        state_d = SYSCALL_ST_IDLE;
      end
    endcase
    if (reset) begin
      stall = 1'b0;
    end
  end

  // Registered request pulse and argument latches; arguments hold between syscalls
  always_ff @(posedge clock) begin
    if (reset) begin
      is_syscall     <= 1'b0;
      syscall_funct  <= '0;
      syscall_param1 <= '0;
    end else begin
      is_syscall <= issue_d;
      if (latch_en) begin
        syscall_funct  <= rf_v0;
        syscall_param1 <= rf_a0;
      end
    end
  end

`ifdef SYSCALL_COUNT_EN
  // Count of issued syscalls; squashed ones never reach ISSUE
  always_ff @(posedge clock) begin
    if (reset) begin
      syscall_count <= '0;
    end else if (state_q == SYSCALL_ST_ISSUE) begin
      syscall_count <= syscall_count + DATA_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_syscall_issue_ctrl.sv
// Scoreboard bench for syscall_issue_ctrl (DRAIN_CYCLES=3). Stimulus queues
// per-cycle expectations and expected pulses; a negedge monitor checks them.
module tb_syscall_issue_ctrl;

  localparam int K_STALL = 0;
  localparam int K_ISSYS = 1;
  localparam int K_FUNCT = 2;
  localparam int K_PARAM = 3;
  localparam int K_COUNT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        id_syscall_valid;
  logic        id_flush;
  logic [31:0] rf_v0;
  logic [31:0] rf_a0;
  logic        stall;
  logic        is_syscall;
  logic [31:0] syscall_funct;
  logic [31:0] syscall_param1;
`ifdef SYSCALL_COUNT_EN
  logic [31:0] syscall_count;
`endif

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
  } chk_t;

  typedef struct {
    int          cyc;
    logic [31:0] funct;
    logic [31:0] param;
  } pulse_t;

  chk_t   chk_q[$];
  pulse_t pulse_q[$];
  pulse_t mon_p;
  int     cyc     = 0;
  int     n_total = 0;
  int     n_pass  = 0;

  syscall_issue_ctrl #(.DRAIN_CYCLES(3)) dut (
    .clock            (clock),
    .reset            (reset),
    .id_syscall_valid (id_syscall_valid),
    .id_flush         (id_flush),
    .rf_v0            (rf_v0),
    .rf_a0            (rf_a0),
    .stall            (stall),
    .is_syscall       (is_syscall),
    .syscall_funct    (syscall_funct),
    .syscall_param1   (syscall_param1)
`ifdef SYSCALL_COUNT_EN
    ,
    .syscall_count    (syscall_count)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
  endtask

  function automatic string kind_name(int k);
    case (k)
      K_STALL: return "stall";
      K_ISSYS: return "is_syscall";
      K_FUNCT: return "syscall_funct";
      K_PARAM: return "syscall_param1";
      default: return "syscall_count";
    endcase
  endfunction

  function automatic logic [31:0] sample(int k);
    case (k)
      K_STALL: return {31'b0, stall};
      K_ISSYS: return {31'b0, is_syscall};
      K_FUNCT: return syscall_funct;
      K_PARAM: return syscall_param1;
`ifdef SYSCALL_COUNT_EN
      K_COUNT: return syscall_count;
`endif
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic exp_at(int c, int k, logic [31:0] v);
    chk_t e;
    e.cyc = c; e.kind = k; e.val = v;
    chk_q.push_back(e);
  endtask

  task automatic exp_stall(int from, int to, logic v);
    for (int c = from; c <= to; c++) exp_at(c, K_STALL, {31'b0, v});
  endtask

  task automatic exp_pulse(int c, logic [31:0] f, logic [31:0] p);
    pulse_t e;
    e.cyc = c; e.funct = f; e.param = p;
    pulse_q.push_back(e);
  endtask

  task automatic exp_count(int c, logic [31:0] v);
`ifdef SYSCALL_COUNT_EN
    exp_at(c, K_COUNT, v);
`endif
  endtask

  task automatic go(int n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Monitor: checks scheduled expectations and every is_syscall pulse
  always @(negedge clock) begin
    if (cyc > 0) begin
      for (int i = chk_q.size() - 1; i >= 0; i--) begin
        if (chk_q[i].cyc == cyc) begin
          check(kind_name(chk_q[i].kind), sample(chk_q[i].kind), chk_q[i].val);
          chk_q.delete(i);
        end
      end
      if (is_syscall === 1'b1) begin
        if (pulse_q.size() == 0) begin
          check("unexpected_pulse", 32'd1, 32'd0);
        end else begin
          mon_p = pulse_q.pop_front();
          check("pulse_cycle", 32'(cyc), 32'(mon_p.cyc));
          check("pulse_funct", syscall_funct, mon_p.funct);
          check("pulse_param1", syscall_param1, mon_p.param);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; id_syscall_valid = 1'b1; id_flush = 1'b0;
    rf_v0 = 32'd0; rf_a0 = 32'd0;
    // Reset state; stall must stay low under reset even with a valid syscall
    exp_stall(1, 2, 1'b0);
    exp_at(2, K_ISSYS, 32'd0);
    exp_at(2, K_FUNCT, 32'd0);
    exp_at(2, K_PARAM, 32'd0);
    exp_count(2, 32'd0);
    go(3); reset = 1'b0; id_syscall_valid = 1'b0;
    exp_stall(3, 5, 1'b0);

    // Basic syscall: stall 10..14, pulse at 14, release at 15
    go(10); rf_v0 = 32'd1; rf_a0 = 32'd42; id_syscall_valid = 1'b1;
    exp_stall(10, 14, 1'b1);
    exp_stall(15, 16, 1'b0);
    exp_pulse(14, 32'd1, 32'd42);
    exp_at(15, K_FUNCT, 32'd1);
    exp_at(15, K_PARAM, 32'd42);
    exp_count(15, 32'd1);
    go(15); id_syscall_valid = 1'b0;

    // Flush in DRAIN: squashed, no pulse, latches unchanged
    go(20); rf_v0 = 32'd5; rf_a0 = 32'd7; id_syscall_valid = 1'b1;
    exp_stall(20, 22, 1'b1);
    exp_stall(23, 24, 1'b0);
    exp_at(25, K_FUNCT, 32'd1);
    exp_at(25, K_PARAM, 32'd42);
    exp_count(25, 32'd1);
    go(22); id_flush = 1'b1;
    go(23); id_flush = 1'b0; id_syscall_valid = 1'b0;

    // Flush in ISSUE ignored; valid held through RELEASE must not re-trigger
    go(30); rf_v0 = 32'd4; rf_a0 = 32'd99; id_syscall_valid = 1'b1;
    exp_stall(30, 34, 1'b1);
    exp_stall(35, 36, 1'b0);
    exp_pulse(34, 32'd4, 32'd99);
    exp_count(35, 32'd2);
    go(34); id_flush = 1'b1;
    go(35); id_flush = 1'b0;
    go(36); id_syscall_valid = 1'b0;

    // Back-to-back: second syscall accepted right after RELEASE, pulses 6 apart
    go(40); rf_v0 = 32'd11; rf_a0 = 32'h41; id_syscall_valid = 1'b1;
    exp_stall(40, 44, 1'b1);
    exp_stall(45, 45, 1'b0);
    exp_stall(46, 50, 1'b1);
    exp_stall(51, 52, 1'b0);
    exp_pulse(44, 32'd11, 32'h41);
    exp_pulse(50, 32'd10, 32'h22);
    exp_count(45, 32'd3);
    exp_count(51, 32'd4);
    exp_at(52, K_FUNCT, 32'd10);
    exp_at(52, K_PARAM, 32'h22);
    go(44); rf_v0 = 32'd10; rf_a0 = 32'h22;
    go(51); id_syscall_valid = 1'b0;

    // Reset in DRAIN: back to IDLE with cleared latches, then a clean run
    go(60); rf_v0 = 32'd3; rf_a0 = 32'd3; id_syscall_valid = 1'b1;
    exp_stall(60, 61, 1'b1);
    exp_stall(62, 62, 1'b0);
    exp_at(63, K_ISSYS, 32'd0);
    exp_at(63, K_FUNCT, 32'd0);
    exp_at(63, K_PARAM, 32'd0);
    exp_count(63, 32'd0);
    exp_stall(63, 67, 1'b1);
    exp_stall(68, 69, 1'b0);
    exp_pulse(67, 32'd3, 32'd3);
    exp_count(68, 32'd1);
    go(62); reset = 1'b1;
    go(63); reset = 1'b0;
    go(68); id_syscall_valid = 1'b0;

    // Reset in ISSUE: pulse already registered, everything cleared next cycle
    go(70); rf_v0 = 32'd6; rf_a0 = 32'd60; id_syscall_valid = 1'b1;
    exp_stall(70, 73, 1'b1);
    exp_stall(74, 76, 1'b0);
    exp_pulse(74, 32'd6, 32'd60);
    exp_at(75, K_ISSYS, 32'd0);
    exp_at(75, K_FUNCT, 32'd0);
    exp_at(75, K_PARAM, 32'd0);
    exp_count(75, 32'd0);
    go(74); reset = 1'b1; id_syscall_valid = 1'b0;
    go(75); reset = 1'b0;

    // Flush with valid in IDLE: no stall, no issue
    go(80); rf_v0 = 32'd9; rf_a0 = 32'd9; id_syscall_valid = 1'b1; id_flush = 1'b1;
    exp_stall(80, 83, 1'b0);
    exp_at(86, K_FUNCT, 32'd0);
    go(82); id_syscall_valid = 1'b0; id_flush = 1'b0;

    go(90);
    check("pulses_outstanding", 32'(pulse_q.size()), 32'd0);
    check("checks_outstanding", 32'(chk_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
